// File: rtl/cc_rect_pkg.sv
// cc_rect_pkg: shared widths, rectangle descriptor and sequencer state for the
// Haar feature sequencer and its corner address generator.
package cc_rect_pkg;
    localparam int W_DATA    = 18;
    localparam int W_WEIGHT  = 3;
    localparam int W_COORD   = 5;
    localparam int II_WIDTH  = 25;
    localparam int W_ADDR    = 10;
    localparam int MAX_RECTS = 3;
    localparam int W_RS_DOUT = 35;
    localparam int W_FSUM    = 37;
    localparam int W_NR      = $clog2(MAX_RECTS + 1);
    localparam int W_RI      = $clog2(MAX_RECTS);
    // Bit k set: corner k sits on the far edge (x+w / y+h); order feeds rect_sum as +,-,+,-
    localparam logic [3:0] CORNER_FAR_X = 4'b0011;
    localparam logic [3:0] CORNER_FAR_Y = 4'b1001;

    typedef struct packed {
        logic [W_COORD-1:0]         x;
        logic [W_COORD-1:0]         y;
        logic [W_COORD-1:0]         w;
        logic [W_COORD-1:0]         h;
        logic signed [W_WEIGHT-1:0] weight;
    } rect_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} seq_state_t;
endpackage

// File: rtl/ii_corner_addr.sv
// ii_corner_addr: integral-image buffer address of one rectangle corner,
// win_base + Y*II_WIDTH + X wrapped to the buffer size.
module ii_corner_addr
    import cc_rect_pkg::*;
(
    input  logic              [1:0] corner,
    input  rect_t                   rect,
    input  logic [W_ADDR-1:0]       base,
    output logic [W_ADDR-1:0]       addr
);
    logic [W_COORD:0]   cx;
    logic [W_COORD:0]   cy;
    logic [W_ADDR+1:0]  sum;

    assign cx   = {1'b0, rect.x} + (CORNER_FAR_X[corner] ? {1'b0, rect.w} : '0);
    assign cy   = {1'b0, rect.y} + (CORNER_FAR_Y[corner] ? {1'b0, rect.h} : '0);
    assign sum  = (W_ADDR+2)'(base) + (W_ADDR+2)'(cy) * (W_ADDR+2)'(II_WIDTH) + (W_ADDR+2)'(cx);
    assign addr = sum[W_ADDR-1:0];
endmodule

// File: rtl/rect_feature_sequencer.sv
// rect_feature_sequencer: walks the rectangles of one Haar feature through rect_sum
// (four corner reads each) and accumulates the weighted results into a feature sum.
module rect_feature_sequencer
    import cc_rect_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        feat_valid,
    output logic                        feat_ready,
    input  rect_t [MAX_RECTS-1:0]       feat_rects,
    input  logic [W_NR-1:0]             feat_nrects,
    input  logic [W_ADDR-1:0]           win_base,
    output logic                        ii_rd_en,
    output logic [W_ADDR-1:0]           ii_addr,
    input  logic [W_DATA-1:0]           ii_rd_data,
    output logic                        rs_rst,
    output logic                        rs_din_valid,
    input  logic                        rs_din_ready,
    output logic [W_DATA-1:0]           rs_din_data,
    output logic                        rs_weight_valid,
    input  logic                        rs_weight_ready,
    output logic signed [W_WEIGHT-1:0]  rs_weight,
    input  logic                        rs_dout_valid,
    output logic                        rs_dout_ready,
    input  logic signed [W_RS_DOUT-1:0] rs_dout_data,
    output logic                        fsum_valid,
    input  logic                        fsum_ready,
    output logic signed [W_FSUM-1:0]    fsum_data
);
    seq_state_t               state;
    rect_t [MAX_RECTS-1:0]    rects;
    logic [W_NR-1:0]          nrects;
    logic [W_NR-1:0]          done;
    logic [W_NR-1:0]          done_next;
    logic [W_ADDR-1:0]        base;
    logic [W_ADDR-1:0]        sel_base;
    logic [W_ADDR-1:0]        addr;
    logic [1:0]               corner;
    logic [1:0]               sel_corner;
    logic [W_RI-1:0]          rect_idx;
    rect_t                    sel_rect;
    logic                     rd_k3;
    logic                     take;
    logic                     unused_ready;
    logic signed [W_FSUM-1:0] acc;
    logic signed [W_FSUM-1:0] acc_next;

    // The first corner is addressed straight from the descriptor so it issues on the accept edge
    assign sel_rect   = (state == IDLE) ? feat_rects[0] : rects[rect_idx];
    assign sel_base   = (state == IDLE) ? win_base : base;
    assign sel_corner = (state == IDLE) ? 2'd0 : corner;

    ii_corner_addr u_addr (
        .corner (sel_corner),
        .rect   (sel_rect),
        .base   (sel_base),
        .addr   (addr)
    );

    assign take          = rs_dout_valid && (state == FETCH || state == DRAIN) && done < nrects;
    assign acc_next      = take ? acc + W_FSUM'(rs_dout_data) : acc;
    assign done_next     = done + W_NR'(take);
    assign rs_din_data   = ii_rd_data;
    assign rs_dout_ready = 1'b1;
    assign unused_ready  = rs_din_ready | rs_weight_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            feat_ready      <= 1'b1;
            rs_rst          <= 1'b1;
            rects           <= '0;
            nrects          <= '0;
            done            <= '0;
            base            <= '0;
            corner          <= '0;
            rect_idx        <= '0;
            rd_k3           <= 1'b0;
            acc             <= '0;
            ii_rd_en        <= 1'b0;
            ii_addr         <= '0;
            rs_din_valid    <= 1'b0;
            rs_weight_valid <= 1'b0;
            rs_weight       <= '0;
            fsum_valid      <= 1'b0;
            fsum_data       <= '0;
        end else begin
            rs_rst          <= 1'b0;
            rs_din_valid    <= ii_rd_en;
            rs_weight_valid <= ii_rd_en && rd_k3;
            acc             <= acc_next;
            done            <= done_next;
            if (take)
                rs_weight <= (done_next < W_NR'(MAX_RECTS)) ? rects[done_next].weight : '0;
            case (state)
                IDLE: if (feat_valid) begin
                    rects      <= feat_rects;
                    nrects     <= feat_nrects;
                    base       <= win_base;
                    acc        <= '0;
                    done       <= '0;
                    rs_weight  <= feat_rects[0].weight;
                    feat_ready <= 1'b0;
                    if (feat_nrects == '0) begin
                        state      <= OUT;
                        fsum_valid <= 1'b1;
                        fsum_data  <= '0;
                    end else begin
                        state    <= FETCH;
                        ii_rd_en <= 1'b1;
                        ii_addr  <= addr;
                        rd_k3    <= 1'b0;
                        corner   <= 2'd1;
                        rect_idx <= '0;
                    end
                end
                FETCH: begin
                    ii_rd_en <= 1'b1;
                    ii_addr  <= addr;
                    rd_k3    <= sel_corner == 2'd3;
                    corner   <= corner + 2'd1;
                    if (corner == 2'd3) begin
                        if (W_NR'(rect_idx) == nrects - 1'b1)
                            state <= DRAIN;
                        else
                            rect_idx <= rect_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    ii_rd_en <= 1'b0;
                    rd_k3    <= 1'b0;
                    if (done_next == nrects) begin
                        state      <= OUT;
                        fsum_valid <= 1'b1;
                        fsum_data  <= acc_next;
                    end
                end
                OUT: if (fsum_ready) begin
                    state      <= IDLE;
                    fsum_valid <= 1'b0;
                    feat_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_dout_expected: assert property (@(posedge clk) disable iff (!rst) rs_dout_valid |-> take);
endmodule
